mips_fetch_unit: RTL and testbench
==================================

MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC width in word addresses; legal range 28..32.
REQ-002 Parameter DATA_W, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, prefetch buffer entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch word address.
- imem_ack  in  1  response valid.
- imem_rdata  in  DATA_W  fetched word.
- inst_valid  out  1  buffer head valid.
- inst_ready  in  1  consumer accepts head.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  head PC.
- redir_valid  in  1  redirect strobe.
- redir_type  in  2  redirect kind: 1 branch, 2 jump, 3 register.
- redir_pc  in  ADDR_W  PC of the redirecting instruction.
- redir_imm  in  16  branch offset, signed.
- redir_addr  in  26  jump field.
- redir_reg  in  ADDR_W  register target.

Function
REQ-006 Word-addressed PC; sequential next PC = PC+1, wrapping modulo 2^ADDR_W.
REQ-007 Redirect targets:
- branch: redir_pc+1+sign_extend(redir_imm).
- jump: {upper ADDR_W-26 bits of redir_pc+1, redir_addr}.
- register: redir_reg.
- type 0 with redir_valid: ignored.
REQ-008 At most one outstanding request; imem_req and imem_addr hold stable from assertion until the imem_ack cycle inclusive.
REQ-009 FSM states:
- IDLE: no request. Go to REQ when buffer free slots exceed in-flight count.
- REQ: request held. On ack, push {rdata, addr}, PC+=1, go IDLE; back-to-back REQ is allowed if a slot remains.
- DRAIN: request held. On ack, discard data and go IDLE.
REQ-010 Buffer is a FIFO with inst_valid = not empty; pop on inst_valid & inst_ready; push and pop in the same cycle is legal when full.
REQ-011 No request is issued while the buffer is full; a request is never dropped for lack of space.
REQ-012 Redirect, effective the next cycle:
- flush the buffer and load the PC with the target;
- REQ with no ack in the same cycle goes to DRAIN, and the new address is issued after drain;
- REQ with ack in the same cycle discards the data and the new address is issued the next cycle;
- IDLE or DRAIN stays/goes to IDLE, or stays in DRAIN with the new target.
REQ-013 Redirect and pop in the same cycle: the pop is accepted (consumer side) and the flush still applies.
REQ-014 inst_valid is low the cycle after a redirect; minimum redirect-to-inst_valid latency is 2 cycles with 0-wait-state memory.
REQ-015 Combinational redirect-to-output paths are forbidden; all outputs are registered or driven from FIFO state.

Reset
REQ-016 While rst_n is low:
- PC=RESET_PC; FSM=IDLE; buffer empty;
- imem_req=0, inst_valid=0, imem_addr=RESET_PC, inst_data=0, inst_pc=0.
REQ-017 First imem_req is asserted in the first cycle after rst_n deasserts.
REQ-018 Reset mid-request abandons the request; a late imem_ack after reset is ignored.

Configuration
REQ-019 Macro MIPS_FETCH_PERF_EN defined adds outputs perf_fetch (32-bit, count of accepted acks kept) and perf_flush (32-bit, count of redirects). Both reset to 0 and saturate at all-ones.
REQ-020 Macro undefined: these ports and counters are absent; all other behaviour is identical.

Structure
REQ-021 Shared package mips_pkg holds:
- the redir_type encodings (REDIR_NONE, REDIR_BRANCH, REDIR_JUMP, REDIR_REG);
- the FSM state typedef;
- the 26-bit jump-field width constant.
REQ-022 One sub-module, fetch_fifo: parametrised DEPTH × (DATA_W+ADDR_W) buffer with flush input, full/empty outputs.

Verification
REQ-023 Reset, RESET_PC=0x100, ack every cycle, ready=1: inst_pc sequence 0x100, 0x101, 0x102, with inst_data matching memory.
REQ-024 ready=0, DEPTH=4: exactly 4 words buffered; imem_req stays low until the first pop.
REQ-025 Branch, redir_pc=0x10, imm=-4 (0xFFFC) during an outstanding request with delayed ack: the ack data is discarded, the next imem_addr is 0x0D, and the next inst_pc is 0x0D.
REQ-026 Jump with redir_pc=0x3FFFFFF, addr=0x0000020, ADDR_W=32: target 0x04000020. Register redirect 0xFFFFFFFF followed by sequential fetch gives addresses 0xFFFFFFFF, 0x00000000.
REQ-027 rst_n low mid-request, then a stale ack: no push occurs, and fetch restarts at RESET_PC. With MIPS_FETCH_PERF_EN, perf_fetch and perf_flush read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction fetch unit: redirect kinds,
// fetch FSM states and the jump-field width.
package mips_pkg;

    localparam int JUMP_W = 26;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_JUMP   = 2'd2,
        REDIR_REG    = 2'd3
    } redir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry FIFO with synchronous flush. The head is
// forced to zero while empty so nothing stale is visible downstream.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// prefetch FIFO, with branch/jump/register redirect. Optional performance
// counters are built when MIPS_FETCH_PERF_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no request outstanding; issue one once a buffer slot is free
// ST_REQ   | request held on imem; ack pushes {rdata, addr} into buffer
// ST_DRAIN | request held after a redirect; ack data is thrown away
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redir_valid,
    input  logic [1:0]        redir_type,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [15:0]       redir_imm,
    input  logic [JUMP_W-1:0] redir_addr,
    input  logic [ADDR_W-1:0] redir_reg
`ifdef MIPS_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_flush
`endif
);
    localparam int                PW  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ONE = 1;

    fetch_state_t              state, state_d;
    logic [ADDR_W-1:0]         pc, pc_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [ADDR_W-1:0]         redir_pc_inc;
    logic [ADDR_W-1:0]         redir_tgt;
    logic                      redir;
    logic                      push, pop;
    logic                      full, empty;
    logic                      slot_free, slot_after;
    logic [PW:0]               count;
    logic [DATA_W+ADDR_W-1:0]  head;

    assign redir        = redir_valid && (redir_type != REDIR_NONE);
    assign inst_valid   = !empty;
    assign pop          = inst_valid && inst_ready;
    assign push         = (state == ST_REQ) && imem_ack && !redir;
    assign slot_free    = !full || pop;
    // room for one more after the word landing this cycle
    assign slot_after   = (int'(count) < DEPTH - 1) || pop;
    assign redir_pc_inc = redir_pc + ONE;

    always_comb begin
        redir_tgt = redir_reg;
        case (redir_type)
            REDIR_BRANCH: redir_tgt = redir_pc_inc + {{(ADDR_W-16){redir_imm[15]}}, redir_imm};
            REDIR_JUMP:   redir_tgt = {redir_pc_inc[ADDR_W-1:JUMP_W], redir_addr};
            default:      redir_tgt = redir_reg;
        endcase
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        case (state)
            ST_IDLE: begin
                if (!redir && slot_free) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redir) begin
                        state_d = ST_REQ;
                    end else begin
                        pc_d    = pc + ONE;
                        state_d = slot_after ? ST_REQ : ST_IDLE;
                    end
                end else if (redir) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (redir) pc_d = redir_tgt;
        // the drained request keeps its address; otherwise track the PC
        addr_d = (state_d == ST_DRAIN) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            addr_q <= addr_d;
        end
    end

    assign imem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    assign imem_addr = addr_q;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redir),
        .push  (push),
        .wdata ({imem_rdata, addr_q}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign inst_data = head[DATA_W+ADDR_W-1:ADDR_W];
    assign inst_pc   = head[ADDR_W-1:0];

`ifdef MIPS_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            if (push && (perf_fetch != '1))  perf_fetch <= perf_fetch + 32'd1;
            if (redir && (perf_flush != '1)) perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios plus a random
// phase, checked against a stream-level model of the fetched PC sequence.
module tb_mips_fetch_unit;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic [31:0] redir_pc;
    logic [15:0] redir_imm;
    logic [25:0] redir_addr;
    logic [31:0] redir_reg;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    logic        mem_auto;
    logic        resp_ack, man_ack;
    logic [31:0] resp_data, man_data;
    assign imem_ack   = mem_auto ? resp_ack : man_ack;
    assign imem_rdata = mem_auto ? resp_data : man_data;

    mips_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .redir_valid (redir_valid),
        .redir_type  (redir_type),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_addr  (redir_addr),
        .redir_reg   (redir_reg)
`ifdef MIPS_FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_flush  (perf_flush)
`endif
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model and responder state
    logic [31:0] exp_pc;
    logic [31:0] last_pop_pc;
    logic [31:0] last_req_addr;
    logic [31:0] prev_addr;
    int          pops, req_starts, acks, flush_model;
    int          wait_left, min_wait, max_wait, ready_pct;
    bit          prev_open, post_redir;
    bit          rq_pend;
    logic [1:0]  rq_type;
    logic [31:0] rq_pc, rq_reg;
    logic [15:0] rq_imm;
    logic [25:0] rq_ja;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] t, input logic [31:0] pc,
                                               input logic [15:0] imm, input logic [25:0] ja,
                                               input logic [31:0] rg);
        int off;
        off = int'($signed(imm));
        case (t)
            2'd1:    return pc + 32'd1 + off;
            2'd2:    return ((pc + 32'd1) & 32'hFC00_0000) | {6'b0, ja};
            default: return rg;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        if (post_redir) chk("valid_after_redir", inst_valid, 1'b0);
        post_redir = 0;
        if (mem_auto) begin
            if (prev_open) chk("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
            if (imem_req) begin
                if (!prev_open) begin
                    req_starts++;
                    last_req_addr = imem_addr;
                    wait_left = $urandom_range(max_wait, min_wait);
                end
                if (wait_left == 0) begin
                    resp_ack  = 1'b1;
                    resp_data = mem_word(imem_addr);
                    acks++;
                    prev_open = 0;
                end else begin
                    resp_ack  = 1'b0;
                    wait_left--;
                    prev_open = 1;
                    prev_addr = imem_addr;
                end
            end else begin
                resp_ack  = 1'b0;
                prev_open = 0;
            end
        end
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        if (inst_valid && inst_ready) begin
            chk("pop_pc", inst_pc, exp_pc);
            chk("pop_data", inst_data, mem_word(exp_pc));
            last_pop_pc = inst_pc;
            exp_pc = exp_pc + 32'd1;
            pops++;
        end
        if (rq_pend) begin
            redir_valid = 1'b1;
            redir_type  = rq_type;
            redir_pc    = rq_pc;
            redir_imm   = rq_imm;
            redir_addr  = rq_ja;
            redir_reg   = rq_reg;
            if (rq_type != 2'd0) begin
                exp_pc = ref_target(rq_type, rq_pc, rq_imm, rq_ja, rq_reg);
                post_redir = 1;
                flush_model++;
            end
            rq_pend = 0;
        end else begin
            redir_valid = 1'b0;
        end
    endtask

    task automatic issue_redir(input logic [1:0] t, input logic [31:0] pc, input logic [15:0] imm,
                               input logic [25:0] ja, input logic [31:0] rg);
        rq_pend = 1; rq_type = t; rq_pc = pc; rq_imm = imm; rq_ja = ja; rq_reg = rg;
        step();
    endtask

    task automatic wait_pop(input string tag, output logic [31:0] pc);
        int start;
        int n;
        start = pops;
        n = 0;
        while (pops == start && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 64'(pops != start), 64'd1);
        pc = last_pop_pc;
    endtask

    task automatic clear_model();
        prev_open = 0; post_redir = 0; rq_pend = 0; resp_ack = 1'b0;
        exp_pc = RESET_PC; flush_model = 0; redir_valid = 1'b0; inst_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
`ifdef MIPS_FETCH_PERF_EN
        chk("rst_perf_fetch", perf_fetch, 32'd0);
        chk("rst_perf_flush", perf_flush, 32'd0);
`endif
        rst_n = 1'b1;
        step();
        chk("first_req", {imem_req, imem_addr}, {1'b1, RESET_PC});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, e;
        int acks0, starts0, n;
        rst_n = 1'b0; mem_auto = 1'b1; man_ack = 1'b0; man_data = '0; resp_data = '0;
        redir_type = '0; redir_pc = '0; redir_imm = '0; redir_addr = '0; redir_reg = '0;
        pops = 0; req_starts = 0; acks = 0; last_pop_pc = '0; last_req_addr = '0; prev_addr = '0;
        wait_left = 0;
        clear_model();

        // streaming from RESET_PC, zero wait, consumer always ready
        min_wait = 0; max_wait = 0; ready_pct = 100;
        do_reset();
        n = pops;
        repeat (9) step();
        chk("stream_pops", pops - n, 9);
        chk("stream_last_pc", last_pop_pc, RESET_PC + 32'd8);

        // consumer stalled: buffer fills to DEPTH, then requests stop
        ready_pct = 0;
        do_reset();
        acks0 = acks - 1;  // do_reset's step acked the first word
        repeat (4) step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("full_no_req", imem_req, 1'b0);
        end
        chk("full_acks", acks - acks0, DEPTH);
        chk("full_valid", inst_valid, 1'b1);
        ready_pct = 100;
        wait_pop("full_pop", got);
        chk("full_first_pc", got, RESET_PC);

        // branch during a stalled request: drain, then fetch the target
        ready_pct = 0; min_wait = 3; max_wait = 3;
        do_reset();
        issue_redir(2'd1, 32'h10, 16'hFFFC, '0, '0);
        starts0 = req_starts;
        min_wait = 0; max_wait = 0;
        n = 0;
        while (req_starts == starts0 && n < 30) begin step(); n++; end
        chk("drain_next_addr", last_req_addr, 32'h0D);
        ready_pct = 100;
        wait_pop("branch_pop", got);
        chk("branch_pc", got, 32'h0D);

        // jump, register redirect with wrap, ignored type 0
        issue_redir(2'd2, 32'h03FF_FFFF, '0, 26'h20, '0);
        wait_pop("jump_pop", got);
        chk("jump_pc", got, 32'h0400_0020);
        issue_redir(2'd3, '0, '0, '0, 32'hFFFF_FFFF);
        wait_pop("reg_pop", got);
        chk("reg_pc", got, 32'hFFFF_FFFF);
        wait_pop("wrap_pop", got);
        chk("wrap_pc", got, 32'h0);
        issue_redir(2'd0, 32'h1234, 16'h8000, 26'h3FF_FFFF, 32'hDEAD_0000);
        e = exp_pc;
        wait_pop("type0_pop", got);
        chk("type0_ignored", got, e);

        // reset in the middle of a request, stale ack afterwards
        min_wait = 3; max_wait = 3; ready_pct = 100;
        do_reset();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        mem_auto = 1'b0; man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
        clear_model();
        inst_ready = 1'b1;
        @(negedge clk);
        chk("midrst_req", imem_req, 1'b0);
`ifdef MIPS_FETCH_PERF_EN
        chk("midrst_perf_fetch", perf_fetch, 32'd0);
        chk("midrst_perf_flush", perf_flush, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        man_ack = 1'b0; mem_auto = 1'b1; resp_ack = 1'b0;
        chk("stale_no_push", inst_valid, 1'b0);
        chk("restart_req", {imem_req, imem_addr}, {1'b1, RESET_PC});
        min_wait = 0; max_wait = 0;
        wait_pop("restart_pop", got);
        chk("restart_pc", got, RESET_PC);

        // random traffic
        n = pops;
        min_wait = 0; max_wait = 3;
        for (int i = 0; i < 2500; i++) begin
            if (i % 200 == 0) ready_pct = $urandom_range(10, 100);
            if ($urandom_range(0, 15) == 0)
                issue_redir(2'($urandom_range(0, 3)), $urandom, 16'($urandom), 26'($urandom),
                            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom);
            else
                step();
        end
        chk("random_progress", 64'(pops - n > 200), 64'd1);
`ifdef MIPS_FETCH_PERF_EN
        step();
        chk("perf_flush_count", perf_flush, 32'(flush_model));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
